// File: rtl/if_fetch_pkg.sv
// Shared widths, reset/pause encodings and IF state encoding for the fetch stage.
package if_fetch_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int STALL_W     = 6;

  localparam logic [INST_W-1:0] ZERO_WORD     = '0;
  localparam logic              RST_ENABLE    = 1'b1;
  localparam logic              PAUSE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_DONE  = 2'd2
  } if_state_e;
endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped instruction cache: combinational lookup, single-word fill.
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INST_ADDR_W-1:2]   lookup_addr,
  output logic                     hit,
  output logic [INST_W-1:0]        rdata,
  input  logic                     fill_en,
  input  logic [INST_ADDR_W-1:2]   fill_addr,
  input  logic [INST_W-1:0]        fill_data
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = INST_ADDR_W - IW - 2;

  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tags [ENTRIES];
  logic [INST_W-1:0]  data [ENTRIES];
  logic [IW-1:0]      lidx, fidx;

  assign lidx  = lookup_addr[IW+1:2];
  assign fidx  = fill_addr[IW+1:2];
  assign hit   = valid[lidx] && (tags[lidx] == lookup_addr[INST_ADDR_W-1:IW+2]);
  assign rdata = data[lidx];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) valid <= '0;
    else if (fill_en)      valid[fidx] <= 1'b1;
  end

  // Tag/data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fidx] <= fill_addr[INST_ADDR_W-1:IW+2];
      data[fidx] <= fill_data;
    end
  end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit LE words from a shared byte port.
// Optional I-cache enabled by defining IF_ICACHE_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC       = 32'h0000_0000,
  parameter int                     ICACHE_ENTRIES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [STALL_W-1:0]     stall_sign,
  input  logic                   branch_flag,
  input  logic [INST_ADDR_W-1:0] branch_target,
  input  logic                   mem_grant,
  input  logic [7:0]             mem_din,
  output logic                   mem_rd_req,
  output logic [INST_ADDR_W-1:0] mem_addr,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst,
  output logic                   if_stall_req
);
  if_state_e              state, state_nx;
  logic [INST_ADDR_W-1:0] pc;
  logic [1:0]             rcnt;
  logic                   inflight;
  logic [23:0]            ibuf;
  logic [2:0]             kcnt;
  logic                   req, got, last, hit;
  logic [INST_W-1:0]      hit_word;
  logic                   unused_stall;

  assign unused_stall = ^stall_sign[STALL_W-1:1];

  // At most one byte is ever in flight, so the issue count is derived.
  assign kcnt = {1'b0, rcnt} + {2'b00, inflight};
  assign got  = rdy && inflight;
  assign last = got && (rcnt == 2'd3);

`ifdef IF_ICACHE_EN
  if_icache #(.ENTRIES(ICACHE_ENTRIES)) u_icache (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (pc[INST_ADDR_W-1:2]),
    .hit         (hit),
    .rdata       (hit_word),
    .fill_en     (rdy && (state == IF_DONE)),
    .fill_addr   (pc[INST_ADDR_W-1:2]),
    .fill_data   (if_inst)
  );
`else
  assign hit      = 1'b0;
  assign hit_word = ZERO_WORD;
`endif

  assign req        = (state == IF_FETCH) && !hit && (kcnt < 3'd4);
  assign mem_rd_req = req;
  assign mem_addr   = req ? pc + {29'd0, kcnt} : ZERO_WORD;

  always_comb begin
    state_nx = state;
    if (rdy) begin
      if (branch_flag) state_nx = IF_FETCH;
      else begin
        case (state)
          IF_IDLE:  state_nx = IF_FETCH;
          IF_FETCH: if (hit || last) state_nx = IF_DONE;
          IF_DONE:  if (stall_sign[0] == PAUSE_DISABLE) state_nx = IF_FETCH;
          default:  state_nx = IF_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state        <= IF_IDLE;
      pc           <= RESET_PC;
      rcnt         <= '0;
      inflight     <= 1'b0;
      ibuf         <= '0;
      if_pc        <= ZERO_WORD;
      if_inst      <= ZERO_WORD;
      if_stall_req <= 1'b1;
    end else if (!rdy) begin
      // Byte landing now is dropped; kcnt falls back so it gets re-requested.
      inflight <= 1'b0;
    end else begin
      state <= state_nx;
      if (branch_flag) begin
        pc           <= branch_target;
        rcnt         <= '0;
        inflight     <= 1'b0;
        if_pc        <= ZERO_WORD;
        if_inst      <= ZERO_WORD;
        if_stall_req <= 1'b1;
      end else begin
        case (state)
          IF_FETCH: begin
            if (hit) begin
              if_pc        <= pc;
              if_inst      <= hit_word;
              if_stall_req <= 1'b0;
            end else begin
              inflight <= req && mem_grant;
              if (got) begin
                ibuf <= {mem_din, ibuf[23:8]};
                rcnt <= rcnt + 2'd1;
              end
              if (last) begin
                if_pc        <= pc;
                if_inst      <= {mem_din, ibuf};
                if_stall_req <= 1'b0;
              end
            end
          end
          IF_DONE: begin
            if (stall_sign[0] == PAUSE_DISABLE) begin
              pc           <= pc + 32'd4;
              if_stall_req <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// Directed and randomized bench for if_fetch against a byte-memory reference model.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [5:0]  stall_sign = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        mem_grant = 1'b1;
  logic [7:0]  mem_din;
  logic        mem_rd_req;
  logic [31:0] mem_addr, if_pc, if_inst;
  logic        if_stall_req;

  logic [7:0]  mem [4096];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_sign(stall_sign),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .mem_grant(mem_grant), .mem_din(mem_din), .mem_rd_req(mem_rd_req),
    .mem_addr(mem_addr), .if_pc(if_pc), .if_inst(if_inst), .if_stall_req(if_stall_req)
  );

  // Byte memory: data one cycle after a granted request, noise otherwise.
  always @(posedge clk)
    mem_din <= (mem_rd_req && mem_grant) ? mem[mem_addr[11:0]] : 8'($urandom);

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] b0, b1, b2, b3;
    b0 = a; b1 = a + 1; b2 = a + 2; b3 = a + 3;
    return {mem[b3[11:0]], mem[b2[11:0]], mem[b1[11:0]], mem[b0[11:0]]};
  endfunction

  task automatic wait_done(input int pct, input int budget, output int n);
    n = 0;
    while (if_stall_req !== 1'b0 && n < budget) begin
      mem_grant = ($urandom_range(99) < pct);
      @(negedge clk); n++;
    end
    mem_grant = 1'b1;
    checks++;
    if (if_stall_req !== 1'b0) begin
      errors++;
      $display("FAIL done_timeout: stall_req=%b after %0d cycles, required 0", if_stall_req, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_rd_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", if_inst); end
    checks++; if (if_stall_req !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b want 1", if_stall_req); end
  endtask

  task automatic test_basic;
    int n;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_rd_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: req=%b addr=%h want 1/0", mem_rd_req, mem_addr); end
    wait_done(100, 50, n);
    checks++; if (n != 5) begin errors++; $display("FAIL latency: got %0d want 5", n); end
    checks++; if (if_inst !== 32'h00100513) begin errors++; $display("FAIL basic_inst: got %h want 00100513", if_inst); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL basic_pc: got %h want 0", if_pc); end
    @(negedge clk);
    checks++; if (mem_rd_req !== 1'b1 || mem_addr !== 32'h4) begin
      errors++; $display("FAIL next_fetch: req=%b addr=%h want 1/4", mem_rd_req, mem_addr); end
    checks++; if (if_stall_req !== 1'b1 || if_pc !== 32'h0) begin
      errors++; $display("FAIL hold_after_done: stall=%b pc=%h want 1/0", if_stall_req, if_pc); end
  endtask

  task automatic test_grant_gaps;
    int c;
    logic [31:0] a2;
    c = 0; a2 = '0;
    while (if_stall_req && c < 20) begin
      mem_grant = !(c == 2 || c == 3);
      if (c == 2) a2 = mem_addr;
      if (c == 3) begin
        checks++; if (mem_addr !== a2 || a2 !== 32'h6) begin
          errors++; $display("FAIL addr_held: got %h/%h want 6/6", a2, mem_addr); end
      end
      @(negedge clk); c++;
    end
    mem_grant = 1'b1;
    checks++; if (c != 7) begin errors++; $display("FAIL gap_latency: got %0d want 7", c); end
    checks++; if (if_inst !== word_at(32'h4) || if_pc !== 32'h4) begin
      errors++; $display("FAIL gap_inst: got %h@%h want %h@4", if_inst, if_pc, word_at(32'h4)); end
  endtask

  task automatic test_branch;
    int n;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_addr !== 32'ha) begin errors++; $display("FAIL byte2_addr: got %h want a", mem_addr); end
    @(negedge clk);
    branch_target = 32'h100; branch_flag = 1'b1;
    @(negedge clk);
    branch_flag = 1'b0;
    checks++; if (if_stall_req !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      errors++; $display("FAIL branch_clear: stall=%b pc=%h inst=%h want 1/0/0", if_stall_req, if_pc, if_inst); end
    checks++; if (mem_rd_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL branch_addr: req=%b addr=%h want 1/100", mem_rd_req, mem_addr); end
    wait_done(100, 50, n);
    checks++; if (if_pc !== 32'h100 || if_inst !== word_at(32'h100)) begin
      errors++; $display("FAIL branch_inst: got %h@%h want %h@100", if_inst, if_pc, word_at(32'h100)); end
  endtask

  task automatic test_stall;
    stall_sign = {5'($urandom), 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (if_stall_req !== 1'b0 || if_pc !== 32'h100 || if_inst !== word_at(32'h100) || mem_rd_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: stall=%b pc=%h inst=%h req=%b", i, if_stall_req, if_pc, if_inst, mem_rd_req); end
    end
    stall_sign = {5'($urandom), 1'b0};
    @(negedge clk);
    stall_sign = '0;
    checks++; if (if_stall_req !== 1'b1 || mem_rd_req !== 1'b1 || mem_addr !== 32'h104) begin
      errors++; $display("FAIL stall_release: stall=%b req=%b addr=%h want 1/1/104", if_stall_req, mem_rd_req, mem_addr); end
  endtask

  task automatic test_rdy;
    int n;
    @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (if_stall_req !== 1'b1 || if_pc !== 32'h100) begin
        errors++; $display("FAIL rdy_freeze%0d: stall=%b pc=%h want 1/100", i, if_stall_req, if_pc); end
    end
    rdy = 1'b1;
    wait_done(100, 50, n);
    checks++; if (if_pc !== 32'h104 || if_inst !== word_at(32'h104)) begin
      errors++; $display("FAIL rdy_inst: got %h@%h want %h@104", if_inst, if_pc, word_at(32'h104)); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_rd_req !== 1'b0 || if_stall_req !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      errors++; $display("FAIL reset_mid: req=%b stall=%b pc=%h inst=%h", mem_rd_req, if_stall_req, if_pc, if_inst); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_rd_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL restart: req=%b addr=%h want 1/0", mem_rd_req, mem_addr); end
  endtask

  task automatic test_random;
    int dones, cyc;
    exp_pc = 32'h0; dones = 0; cyc = 0;
    while (cyc < 6000 && dones < 60) begin
      if (if_stall_req === 1'b0) begin
        checks++; if (if_pc !== exp_pc || if_inst !== word_at(exp_pc)) begin
          errors++; $display("FAIL rand_inst: got %h@%h want %h@%h", if_inst, if_pc, word_at(exp_pc), exp_pc); end
      end
      mem_grant     = ($urandom_range(3) != 0);
      rdy           = ($urandom_range(15) != 0);
      stall_sign    = {5'($urandom), ($urandom_range(3) == 0)};
      branch_flag   = ($urandom_range(19) == 0);
      branch_target = {20'd0, 10'($urandom), 2'b00};
      if (rdy) begin
        if (branch_flag) exp_pc = branch_target;
        else if (if_stall_req === 1'b0 && !stall_sign[0]) begin exp_pc = exp_pc + 4; dones++; end
      end
      @(negedge clk); cyc++;
    end
    rdy = 1'b1; branch_flag = 1'b0; stall_sign = '0; mem_grant = 1'b1;
    checks++; if (dones < 60) begin errors++; $display("FAIL rand_progress: %0d instructions, want 60", dones); end
  endtask

`ifdef IF_ICACHE_EN
  task automatic test_icache;
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      branch_target = 32'h0; branch_flag = 1'b1;
      @(negedge clk);
      branch_flag = 1'b0;
      if (pass == 0) wait_done(100, 50, n);
      else begin
        checks++; if (mem_rd_req !== 1'b0 || if_stall_req !== 1'b1) begin
          errors++; $display("FAIL hit_noreq: req=%b stall=%b want 0/1", mem_rd_req, if_stall_req); end
        @(negedge clk);
        checks++; if (if_stall_req !== 1'b0 || if_pc !== 32'h0 || if_inst !== word_at(32'h0)) begin
          errors++; $display("FAIL hit_done: stall=%b got %h@%h want %h@0", if_stall_req, if_inst, if_pc, word_at(32'h0)); end
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    mem[12'h100] = 8'h5a; mem[12'h101] = 8'h5b; mem[12'h102] = 8'h5c; mem[12'h103] = 8'h5d;
    mem[10] = 8'ha5;
    test_reset;
    test_basic;
    test_grant_gaps;
    test_branch;
    test_stall;
    test_rdy;
    test_reset_mid;
    test_random;
`ifdef IF_ICACHE_EN
    test_icache;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC and assembles each 32-bit little-endian instruction from a byte-wide memory port shared with MEM via the memory arbiter. Raises a stall request to ctrl while a fetch is in flight and redirects on branch/jump from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ICACHE_ENTRIES, 16, entries in the optional direct-mapped I-cache (power of two)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high (`RstEnable` = 1'b1)
rdy  in  1  global ready; low freezes all state
stall_sign  in  6  from ctrl; bit0 = hold PC/IF
branch_flag  in  1  redirect request from EX
branch_target  in  32  redirect address
mem_grant  in  1  arbiter grants this cycle's byte request to IF
mem_din  in  8  read byte; valid the cycle after a granted request
mem_rd_req  out  1  byte read request to arbiter
mem_addr  out  32  byte address of the request
if_pc  out  32  PC of assembled instruction, to if_id
if_inst  out  32  assembled instruction, to if_id
if_stall_req  out  1  to ctrl; high while the instruction is not ready

Behaviour:
- Reset: pc=RESET_PC, state=IDLE, mem_rd_req=0, mem_addr=0, if_pc=0, if_inst=0, if_stall_req=1, byte buffer cleared; I-cache valid bits cleared.
- rdy=0: no register changes; any mem_din arriving that cycle is dropped and its byte re-requested once rdy returns.
- States: IDLE, FETCH, DONE.
- IDLE -> FETCH next cycle (no stall gating).
- FETCH: issue counter k (0..3), receive counter r (0..3). mem_rd_req=1, mem_addr=pc+k while k<4. Granted request -> k++. Byte arriving the cycle after a grant -> buf[8r+7:8r], r++. Requests pipelined: with continuous grant, request for byte k+1 overlaps receipt of byte k.
- Ungranted cycle: k unchanged, address held.
- r reaches 4 -> DONE. Minimum latency with continuous grant: 5 cycles from entering FETCH to DONE.
- DONE (one cycle): if_pc=pc, if_inst=buf, if_stall_req=0.
  - stall_sign[0]=0: pc<=pc+4 (32-bit wrap), go to FETCH.
  - stall_sign[0]=1: stay in DONE, outputs held, stall_req held 0.
- if_stall_req=1 in IDLE and FETCH.
- if_pc/if_inst outside DONE: hold last value (if_id bubbles while stall_req=1).
- branch_flag=1 (any state, rdy=1): pc<=branch_target, k=r=0, in-flight byte discarded, state<=FETCH, if_inst<=0, if_pc<=0, if_stall_req<=1. Branch wins over a simultaneous DONE/pc+4.
- Branch while a granted byte is in flight: the returning byte next cycle is ignored.
- Reset mid-fetch: abandon immediately; mem_rd_req=0 in the cycle after reset.

Optional Feature:
IF_ICACHE_EN.
- Defined: direct-mapped cache, ICACHE_ENTRIES words.
  - index = pc[log2(ICACHE_ENTRIES)+1:2]; tag = remaining upper bits.
  - On entering FETCH, a hit goes straight to DONE the next cycle with the cached word; no mem_rd_req.
  - A miss fetches as above and fills the line on DONE.
  - Branch redirect never invalidates lines.
- Undefined: no cache storage; every instruction fetched from memory.

Decomposition:
- Shared defines: `InstAddrBus, `InstBus, `StallBus, `ZeroWord, `RstEnable, `PauseDisable, and state encodings IF_IDLE/IF_FETCH/IF_DONE.
- One sub-module: if_icache (tag/data/valid arrays, lookup and fill ports), instantiated only under IF_ICACHE_EN.

Test Plan:
- Reset, continuous grant, memory[0..3]=13 05 10 00 -> DONE at cycle 5 with if_inst=32'h00100513, if_pc=0, then fetch at pc=4.
- mem_grant low on cycles 2-3 of a fetch -> mem_addr held; inst assembled correctly at cycle 7.
- branch_flag with target 32'h0000_0100 while byte 2 is in flight -> stray byte ignored; next DONE has if_pc=0x100 and bytes from 0x100..0x103.
- stall_sign[0]=1 during DONE for 3 cycles -> pc, if_inst and stall_req=0 held; advances to pc+4 when stall released.
- rdy low for 2 cycles mid-fetch -> no state change; completed instruction identical to the uninterrupted case.
- With IF_ICACHE_EN, loop branching back to 0x0 -> second visit reaches DONE in 1 cycle with mem_rd_req never asserted.
